// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one combinational ALU. Each port has a
// one-deep response buffer, and a saturating counter tracks contention.

module alu_share_rsp_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_i,
  input  logic              rdy_i,
  input  logic [DATA_W-1:0] res_i,
  input  logic              err_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  output logic              zero_o,
  output logic              sign_o,
  output logic              err_o
);
  logic              vld_q, zero_q, sign_q, err_q;
  logic [DATA_W-1:0] data_q;

  // On drain only valid clears; data and flags keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (acc_i) begin
      vld_q  <= 1'b1;
      data_q <= res_i;
      zero_q <= (res_i == '0);
      sign_q <= res_i[DATA_W-1];
      err_q  <= err_i;
    end else if (rdy_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign zero_o = zero_q;
  assign sign_o = sign_q;
  assign err_o  = err_q;
endmodule

module alu_share_arbiter #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 3,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_first_operand,
  output logic [DATA_W-1:0] alu_second_operand,
  output logic [OP_W-1:0]   alu_oper_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_sign,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_sign,
  output logic              rsp1_err,
  output logic [CNT_W-1:0]  contention_cnt
);
  logic [1:0]             req_vld, rsp_vld, rsp_rdy, elig, gnt;
  logic [1:0][DATA_W-1:0] rsp_data;
  logic [1:0]             rsp_zero, rsp_sign, rsp_err;
  logic                   ptr_q, ptr_d, both, op_err;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign req_vld = {req1_valid, req0_valid};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};
  // Gated by reset so nothing is granted while the block is held in reset.
  assign elig    = req_vld & (~rsp_vld | rsp_rdy) & {2{rst_n}};
  assign both    = &elig;

  always_comb begin
    gnt = elig;
    if (both) gnt = (FIXED_PRIO != 0 || ptr_q) ? 2'b01 : 2'b10;
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    alu_first_operand  = '0;
    alu_second_operand = '0;
    alu_oper_sel       = '0;
    if (gnt[0]) begin
      alu_first_operand  = req0_a;
      alu_second_operand = req0_b;
      alu_oper_sel       = req0_op;
    end else if (gnt[1]) begin
      alu_first_operand  = req1_a;
      alu_second_operand = req1_b;
      alu_oper_sel       = req1_op;
    end
  end

  assign op_err = (alu_oper_sel == OP_W'(3));

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (|gnt) ptr_d = gnt[1];
    if (both && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign contention_cnt = cnt_q;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    alu_share_rsp_slot #(.DATA_W(DATA_W)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .acc_i  (gnt[g]),
      .rdy_i  (rsp_rdy[g]),
      .res_i  (alu_result),
      .err_i  (op_err),
      .vld_o  (rsp_vld[g]),
      .data_o (rsp_data[g]),
      .zero_o (rsp_zero[g]),
      .sign_o (rsp_sign[g]),
      .err_o  (rsp_err[g])
    );
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp0_data  = rsp_data[0];
  assign rsp0_zero  = rsp_zero[0];
  assign rsp0_sign  = rsp_sign[0];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp1_data  = rsp_data[1];
  assign rsp1_zero  = rsp_zero[1];
  assign rsp1_sign  = rsp_sign[1];
  assign rsp1_err   = rsp_err[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus,
// each driving its own behavioural ALU.

module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;

  logic        rr_r0, rr_r1, rr_v0, rr_v1, rr_z0, rr_z1, rr_s0, rr_s1, rr_e0, rr_e1;
  logic [31:0] rr_fa, rr_sa, rr_res, rr_d0, rr_d1;
  logic [2:0]  rr_op;
  logic [15:0] rr_cnt;
  logic        fx_r0, fx_r1, fx_v0, fx_v1, fx_z0, fx_z1, fx_s0, fx_s1, fx_e0, fx_e1;
  logic [31:0] fx_fa, fx_sa, fx_res, fx_d0, fx_d1;
  logic [2:0]  fx_op;
  logic [15:0] fx_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return a - b;
      3'b100:  return a ^ b;
      3'b101:  return a >> b[4:0];
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign rr_res = alu(rr_fa, rr_sa, rr_op);
  assign fx_res = alu(fx_fa, fx_sa, fx_op);

  alu_share_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rr_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(rr_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_first_operand(rr_fa), .alu_second_operand(rr_sa), .alu_oper_sel(rr_op), .alu_result(rr_res),
    .rsp0_valid(rr_v0), .rsp0_ready(rsp0_ready), .rsp0_data(rr_d0), .rsp0_zero(rr_z0),
    .rsp0_sign(rr_s0), .rsp0_err(rr_e0),
    .rsp1_valid(rr_v1), .rsp1_ready(rsp1_ready), .rsp1_data(rr_d1), .rsp1_zero(rr_z1),
    .rsp1_sign(rr_s1), .rsp1_err(rr_e1),
    .contention_cnt(rr_cnt)
  );

  alu_share_arbiter #(.FIXED_PRIO(1)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fx_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(fx_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_first_operand(fx_fa), .alu_second_operand(fx_sa), .alu_oper_sel(fx_op), .alu_result(fx_res),
    .rsp0_valid(fx_v0), .rsp0_ready(rsp0_ready), .rsp0_data(fx_d0), .rsp0_zero(fx_z0),
    .rsp0_sign(fx_s0), .rsp0_err(fx_e0),
    .rsp1_valid(fx_v1), .rsp1_ready(rsp1_ready), .rsp1_data(fx_d1), .rsp1_zero(fx_z1),
    .rsp1_sign(fx_s1), .rsp1_err(fx_e1),
    .contention_cnt(fx_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run between edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b000;
    req1_a = 32'd7;  req1_b = 32'd2;  req1_op = 3'b010;
    #3;
    chk("rst_ready0", rr_r0, 0);
    chk("rst_ready1", rr_r1, 0);
    chk("rst_rsp0_valid", rr_v0, 0);
    chk("rst_rsp1_valid", rr_v1, 0);
    chk("rst_cnt", rr_cnt, 0);
    chk("rst_fx_ready0", fx_r0, 0);
    tick(); tick();
    rst_n = 1'b1;
    #2;

    // Contention: round-robin alternates starting at port 0, fixed stays on 0.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_gnt0_c%0d", i), rr_r0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_gnt1_c%0d", i), rr_r1, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("fx_gnt0_c%0d", i), fx_r0, 1);
      chk($sformatf("fx_gnt1_c%0d", i), fx_r1, 0);
      tick(); #2;
    end
    chk("rr_cnt4", rr_cnt, 4);
    chk("fx_cnt4", fx_cnt, 4);
    chk("rr_rsp0_add", rr_d0, 30);
    chk("rr_rsp1_sub", rr_d1, 5);
    chk("fx_rsp1_never", fx_v1, 0);

    // Idle: ALU inputs are forced to zero when nothing is granted.
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("idle_op", rr_op, 0);
    chk("idle_fa", rr_fa, 0);
    chk("idle_sa", rr_sa, 0);
    tick();
    chk("idle_drain0", rr_v0, 0);
    chk("idle_drain1", rr_v1, 0);
    chk("idle_data_kept", rr_d0, 30);
    chk("idle_cnt", rr_cnt, 4);

    // Single requests on port 0.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b010;
    #1;
    chk("pass_fa", rr_fa, 5);
    chk("pass_op", rr_op, 3'b010);
    tick();
    chk("sub_valid", rr_v0, 1);
    chk("sub_data", rr_d0, 2);
    chk("sub_zero", rr_z0, 0);
    chk("sub_sign", rr_s0, 0);
    req0_a = 32'd3; req0_b = 32'd3;
    tick();
    chk("sub0_data", rr_d0, 0);
    chk("sub0_zero", rr_z0, 1);
    chk("sub0_valid", rr_v0, 1);

    // Backpressure on port 1.
    req0_valid = 1'b0; rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd31; req1_op = 3'b001;
    tick();
    chk("bp_valid1", rr_v1, 1);
    chk("bp_data1", rr_d1, 32'h8000_0000);
    chk("bp_sign1", rr_s1, 1);
    req1_a = 32'd2; req1_b = 32'd2; req1_op = 3'b000;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("bp_rdy1_c%0d", i), rr_r1, 0);
      chk($sformatf("bp_rdy0_c%0d", i), rr_r0, 1);
      tick();
      chk($sformatf("bp_hold_c%0d", i), rr_d1, 32'h8000_0000);
      chk($sformatf("bp_hold_v_c%0d", i), rr_v1, 1);
    end
    chk("bp_rsp0", rr_d0, 2);
    chk("bp_cnt", rr_cnt, 4);
    rsp1_ready = 1'b1;
    #1;
    chk("bp_release_rdy1", rr_r1, 1);
    chk("bp_release_rdy0", rr_r0, 0);
    tick();
    chk("bp_new_data1", rr_d1, 4);
    chk("bp_new_sign1", rr_s1, 0);
    chk("bp_cnt5", rr_cnt, 5);

    // Unsupported op 011 is forwarded and flagged.
    req1_valid = 1'b0;
    req0_a = 32'd9; req0_b = 32'd9; req0_op = 3'b011;
    #1;
    chk("err_fwd_op", rr_op, 3'b011);
    tick();
    chk("err_flag", rr_e0, 1);
    chk("err_data", rr_d0, 0);
    req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 3'b000;
    tick();
    chk("wrap_data", rr_d0, 0);
    chk("wrap_zero", rr_z0, 1);
    chk("wrap_err", rr_e0, 0);

    // Asynchronous reset between edges while a response is pending.
    req0_valid = 1'b0; rsp0_ready = 1'b0;
    #2;
    chk("pre_arst_valid", rr_v0, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid0", rr_v0, 0);
    chk("arst_cnt", rr_cnt, 0);
    tick();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single 32-bit combinational ALU between two requesters: port 0 is the main execute path and port 1 is the address/branch-compare helper. The block arbitrates per cycle with a valid/ready handshake and drives the ALU operand and op-select inputs. It captures the ALU result into a one-deep response buffer per requester, which is held until that requester consumes it. It also keeps a saturating contention counter for performance debug.

Parameters:
DATA_W, 32, operand/result width; must match the ALU.
OP_W, 3, op-select width; ALU encoding: 000 add, 001 sll, 010 sub, 100 xor, 101 srl, 110 or, 111 and.
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins contention.
CNT_W, 16, width of contention counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
reqN_valid  in  1  (N=0,1) request valid
reqN_ready  out  1  (N=0,1) request accepted this cycle (combinational grant)
reqN_a  in  DATA_W  (N=0,1) first operand
reqN_b  in  DATA_W  (N=0,1) second operand
reqN_op  in  OP_W  (N=0,1) ALU op-select
alu_first_operand  out  DATA_W  to ALU
alu_second_operand  out  DATA_W  to ALU
alu_oper_sel  out  OP_W  to ALU
alu_result  in  DATA_W  ALU combinational output, same cycle
rspN_valid  out  1  (N=0,1) response buffer holds result
rspN_ready  in  1  (N=0,1) requester consumes response
rspN_data  out  DATA_W  (N=0,1) registered result
rspN_zero  out  1  (N=0,1) result == 0
rspN_sign  out  1  (N=0,1) result[DATA_W-1]
rspN_err  out  1  (N=0,1) op was unsupported code 011
contention_cnt  out  CNT_W  cycles with both ports eligible

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values: all rsp* outputs 0, contention_cnt 0, last-grant pointer = 1, so port 0 wins the first contention.
- Eligibility: eligN = reqN_valid & (~rspN_valid | rspN_ready). A port whose buffer is full and not being drained is not granted.
- Grant when exactly one port is eligible: that port.
- Grant when both are eligible:
  - FIXED_PRIO=1: port 0.
  - Otherwise: the port not equal to the last-grant pointer.
- reqN_ready = grantN, combinational. Requesters must not derive valid from ready.
- Pointer: updates to the granted index on every grant. No grant leaves it unchanged.
- ALU drive:
  - Granted port: its a/b/op pass straight through to the ALU.
  - No grant: operands 0, op 000.
- Capture:
  - On the accept cycle edge, rspN_data <= alu_result.
  - rspN_zero <= (alu_result == 0), computed locally from the result.
  - rspN_sign <= alu_result[DATA_W-1].
  - rspN_err <= (op == 011).
  - rspN_valid <= 1.
  - Request-to-response latency is 1 cycle.
- Op 011 is still accepted and forwarded to the ALU. The response is flagged err; data is whatever the ALU returns (0 for the current ALU).
- Hold: while rspN_valid & ~rspN_ready, rspN_* are stable.
- Drain with no new accept: rspN_valid <= 0. The data/flag registers keep their last values.
- Simultaneous drain and new accept on the same port: the buffer reloads with the new result and rspN_valid stays 1. Full throughput is one op per cycle per port.
- Port independence: both buffers may be valid at once. Draining one never affects the other.
- contention_cnt: increments on every cycle where elig0 & elig1, and saturates at all-ones.
- Reset mid-operation: buffers are cleared and pending responses are discarded. Requesters reissue.

Test Plan:
- Reset: hold rst_n=0 with both reqN_valid=1 -> reqN_ready=0, rspN_valid=0, contention_cnt=0. Release -> port 0 is granted first.
- Single request: req0 a=5, b=3, op=010, rsp0_ready=1 -> next cycle rsp0_valid=1, rsp0_data=2, zero=0, sign=0. Then a=3, b=3, op=010 -> data 0, zero=1.
- Round-robin contention: both valid for 4 cycles, both rspN_ready=1 -> grants 0,1,0,1; contention_cnt=4. With FIXED_PRIO=1 -> grants 0,0,0,0.
- Backpressure: rsp1_ready=0 after one accepted req1 (a=1, b=31, op=001) -> rsp1_data=0x80000000, sign=1 held. req1_ready stays 0 while port 0 keeps getting grants. Assert rsp1_ready -> req1 is granted in that same cycle.
- Error op: req0 op=011 -> rsp0_err=1, data 0. A following op=000 with a=0xFFFFFFFF, b=1 -> data 0, zero=1, err=0.
- Async reset mid-op: assert rst_n low between clock edges while rsp0_valid=1 -> rsp0_valid drops immediately with no clock edge.
